// File: rtl/uart_alu_intf.sv
`default_nettype none
// ============================================================================
// Module   : uart_alu_intf
// Brief    : Assembles A, B and opcode bytes from rx_uart, latches the ALU
//            result and hands it to the UART transmitter.
//            Optional inter-byte timeout: define UART_INTF_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module uart_alu_intf #(
  parameter int NB_DATA        = 8,
  parameter int NB_OP          = 6,
  parameter int NB_TIMEOUT     = 24,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_timeout
);

  localparam logic [2:0] c_st_wait_a  = 3'd0;
  localparam logic [2:0] c_st_wait_b  = 3'd1;
  localparam logic [2:0] c_st_wait_op = 3'd2;
  localparam logic [2:0] c_st_calc    = 3'd3;
  localparam logic [2:0] c_st_send    = 3'd4;
  localparam logic [2:0] c_st_wait_tx = 3'd5;

  localparam logic [NB_TIMEOUT-1:0] c_timeout_last = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  logic [2:0]         r_state;
  logic [2:0]         w_next_state;
  logic               w_timeout;
  logic [NB_DATA-1:0] r_alu_a;
  logic [NB_DATA-1:0] r_alu_b;
  logic [NB_OP-1:0]   r_alu_op;
  logic [NB_DATA-1:0] r_tx_data;

`ifdef UART_INTF_TIMEOUT_EN
  logic [NB_TIMEOUT-1:0] r_timeout_cnt;
  logic                  w_counting;

  assign w_counting = (r_state == c_st_wait_b) || (r_state == c_st_wait_op);
  // A byte landing in the expiry cycle takes priority over the abort.
  assign w_timeout  = w_counting && !i_rx_done_tick && (r_timeout_cnt == c_timeout_last);

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_timeout_cnt <= '0;
    end else if (!w_counting || i_rx_done_tick) begin
      r_timeout_cnt <= '0;
    end else begin
      r_timeout_cnt <= r_timeout_cnt + 1'b1;
    end
  end
`else
  logic w_unused_timeout_cfg;

  assign w_unused_timeout_cfg = ^c_timeout_last;
  assign w_timeout            = 1'b0;
`endif

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= c_st_wait_a;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_wait_a:  if (i_rx_done_tick) w_next_state = c_st_wait_b;
      c_st_wait_b: begin
        if (i_rx_done_tick) w_next_state = c_st_wait_op;
        else if (w_timeout) w_next_state = c_st_wait_a;
      end
      c_st_wait_op: begin
        if (i_rx_done_tick) w_next_state = c_st_calc;
        else if (w_timeout) w_next_state = c_st_wait_a;
      end
      c_st_calc:    w_next_state = c_st_send;
      c_st_send:    w_next_state = c_st_wait_tx;
      c_st_wait_tx: if (i_tx_done_tick) w_next_state = c_st_wait_a;
      default:      w_next_state = c_st_wait_a;
    endcase
  end

  always_comb begin
    o_tx_start = (r_state == c_st_send);
    o_busy     = (r_state == c_st_calc) || (r_state == c_st_send) || (r_state == c_st_wait_tx);
    o_timeout  = w_timeout;
  end

  // Operand fields persist across frames; only the byte slot being filled moves.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_alu_a   <= '0;
      r_alu_b   <= '0;
      r_alu_op  <= '0;
      r_tx_data <= '0;
    end else begin
      if ((r_state == c_st_wait_a) && i_rx_done_tick) r_alu_a <= i_rx_data;
      if ((r_state == c_st_wait_b) && i_rx_done_tick) r_alu_b <= i_rx_data;
      if ((r_state == c_st_wait_op) && i_rx_done_tick) r_alu_op <= i_rx_data[NB_OP-1:0];
      if (r_state == c_st_calc) r_tx_data <= i_alu_result;
    end
  end

  assign o_alu_a   = r_alu_a;
  assign o_alu_b   = r_alu_b;
  assign o_alu_op  = r_alu_op;
  assign o_tx_data = r_tx_data;

endmodule
`default_nettype wire
